// File: rtl/fsk_carrier_div.sv
// Glitch-free programmable carrier divider: one of NUM_SEL period lengths, chosen
// by priority switches, changed or stopped only at the end of a low phase.
module fsk_carrier_div #(
  parameter int                       NUM_SEL   = 4,
  parameter int                       CNT_W     = 24,
  parameter logic [NUM_SEL*CNT_W-1:0] DIV_TABLE = {24'd8192, 24'd16384, 24'd32768, 24'd65536}
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic [NUM_SEL-1:0] sel,
  output logic               clk_out,
  output logic               tick,
  output logic [NUM_SEL-1:0] active_sel,
  output logic               switching
);

  localparam int IDX_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   h_len;
  logic [CNT_W-1:0]   l_len;

  logic [NUM_SEL-1:0] req;
  logic [IDX_W-1:0]   req_idx;
  logic [CNT_W-1:0]   req_div;
  logic [CNT_W-1:0]   req_h;
  logic [CNT_W-1:0]   req_l;

  // Priority decode: the highest-index set switch wins, so later iterations overwrite.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    req     = '0;
    req_idx = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (sel[i]) begin
        req     = '0;
        req[i]  = 1'b1;
        req_idx = IDX_W'(i);
      end
    end
  end

  // Phase lengths of the requested ratio; odd periods put the extra cycle in the low phase.
  always_comb begin
    req_div = DIV_TABLE[int'(req_idx)*CNT_W +: CNT_W];
    if (req_div < CNT_W'(2)) req_div = CNT_W'(2);
    req_h = req_div >> 1;
    req_l = req_div - req_h;
  end

  // Gated by reset so the status pin reads 0 while the block is held in reset.
  assign switching = rst_n && (req != active_sel);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      h_len      <= '0;
      l_len      <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      active_sel <= '0;
    end else begin
      tick <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt     <= '0;
          clk_out <= 1'b0;
          if (req != '0) begin
            state      <= RUN;
            active_sel <= req;
            h_len      <= req_h;
            l_len      <= req_l;
          end
        end
        RUN: begin
          if (!clk_out) begin
            if (cnt == l_len - CNT_W'(1)) begin
              // End of a low phase: the only point where the ratio may change or stop.
              cnt <= '0;
              if (req == '0) begin
                state      <= IDLE;
                active_sel <= '0;
              end else begin
                active_sel <= req;
                h_len      <= req_h;
                l_len      <= req_l;
                clk_out    <= 1'b1;
                tick       <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            if (cnt == h_len - CNT_W'(1)) begin
              cnt     <= '0;
              clk_out <= 1'b0;
              tick    <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
